// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants; PARITY state exists only with UART_RX_PARITY_EN.
package uart_pkg;
  localparam int W_DATA = 8;
  localparam int OVERSAMPLE_DEF = 16;
  typedef logic [W_DATA-1:0] data_t;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_e;
endpackage

// File: rtl/sipo.sv
// sipo: 8-bit LSB-first serial-in/parallel-out shift register with even-parity output.
module sipo
  import uart_pkg::*;
(
  input  logic  clk,
  input  logic  enb,
  input  logic  inp,
  output data_t out,
  output logic  parity
);
  // Not reset: eight shifts fully overwrite the contents before use.
  always_ff @(posedge clk)
    if (enb) out <= {inp, out[W_DATA-1:1]};
  assign parity = ^out;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer driving a sipo, with one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive and check an even-parity bit between data and stop.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rx_i,
  input  logic  baud_tick_i,
  output data_t data_o,
  output logic  valid_o,
  input  logic  ready_i,
  output logic  frame_err_o,
  output logic  parity_err_o,
  output logic  overrun_o
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

  rx_state_e state_q, state_d;
  logic sync_q, rx_s_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  data_t data_q, data_d, sr_out;
  logic valid_q, valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic sr_enb, sr_par, mid, smp;
`ifdef UART_RX_PARITY_EN
  logic mis_q, mis_d, parity_err_q, parity_err_d;
  assign parity_err_o = parity_err_q;
`else
  logic unused_par;
  assign unused_par = sr_par;
  assign parity_err_o = 1'b0;
`endif

  sipo u_sipo (
    .clk   (clk),
    .enb   (sr_enb),
    .inp   (rx_s_q),
    .out   (sr_out),
    .parity(sr_par)
  );

  assign mid = baud_tick_i && tick_q == T_MID;
  assign smp = baud_tick_i && tick_q == T_END;
  assign data_o = data_q;
  assign valid_o = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o = overrun_q;

  always_comb begin
    state_d = state_q;
    tick_d = baud_tick_i ? tick_q + TW'(1) : tick_q;
    bit_d = bit_q;
    data_d = data_q;
    valid_d = valid_q & ~ready_i;
    frame_err_d = 1'b0;
    overrun_d = 1'b0;
    sr_enb = 1'b0;
`ifdef UART_RX_PARITY_EN
    mis_d = mis_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        tick_d = '0;
      end
      START: if (mid) begin
        state_d = rx_s_q ? IDLE : DATA;
        tick_d = '0;
        bit_d = '0;
      end
      DATA: if (smp) begin
        sr_enb = 1'b1;
        tick_d = '0;
        bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        state_d = (bit_q == 3'd7) ? PARITY : DATA;
`else
        state_d = (bit_q == 3'd7) ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (smp) begin
        tick_d = '0;
        mis_d = rx_s_q ^ sr_par;
        state_d = STOP;
      end
`endif
      STOP: if (smp) begin
        tick_d = '0;
        state_d = IDLE;
        if (!rx_s_q) begin
          frame_err_d = 1'b1;
          state_d = WAIT_HIGH;
        end
`ifdef UART_RX_PARITY_EN
        else if (mis_q) parity_err_d = 1'b1;
`endif
        else if (!valid_q || ready_i) begin
          data_d = sr_out;
          valid_d = 1'b1;
        end else overrun_d = 1'b1;
      end
      WAIT_HIGH: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
      tick_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      mis_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q <= rx_i;
      rx_s_q <= sync_q;
      tick_q <= tick_d;
      bit_q <= bit_d;
      data_q <= data_d;
      valid_q <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
`ifdef UART_RX_PARITY_EN
      mis_q <= mis_d;
      parity_err_q <= parity_err_d;
`endif
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scenario tasks plus randomized frames checked against a frame-level model.
module tb_uart_rx_ctrl;
  import uart_pkg::*;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 10;
  localparam bit PAR = 1'b0;
`endif
  // Stop bit sampled on the clk edge at this offset from the start-bit edge
  localparam int T_DONE = 11 + OS * (NB - 1);

  logic clk = 1'b0, rst = 1'b0, rx_i = 1'b1, baud_tick_i = 1'b1, ready_i = 1'b0;
  data_t data_o;
  logic valid_o, frame_err_o, parity_err_o, overrun_o;
  int n_pass = 0, n_total = 0, n_fe = 0, n_pe = 0, n_ov = 0;
  int fe0, pe0, ov0;

  uart_rx_ctrl #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .baud_tick_i(baud_tick_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err_o) n_fe++;
    if (parity_err_o) n_pe++;
    if (overrun_o) n_ov++;
  end

  task automatic snap();
    fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
  endtask

  task automatic send(input data_t b, input logic par_ok, input logic stop, input int rdy_at);
    logic bits [11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9] = (^b) ^ !par_ok;
    bits[10] = 1'b1;
    bits[NB-1] = stop;
    for (int c = 0; c < NB * OS; c++) begin
      rx_i = bits[c/OS];
      ready_i = (c == rdy_at);
      @(negedge clk);
    end
    ready_i = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL %s_drain: valid_o got %b expected 0", name, valid_o); else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if ({valid_o, frame_err_o, parity_err_o, overrun_o} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000", {valid_o, frame_err_o, parity_err_o, overrun_o});
    else n_pass++;
    n_total++;
    if (data_o !== 8'h00) $display("FAIL reset_data: got %h expected 00", data_o); else n_pass++;
    rst = 1'b1;
    idle(5);
  endtask

  task automatic test_good();
    snap();
    send(8'hA5, 1'b1, 1'b1, -1);
    n_total++;
    if (valid_o !== 1'b1 || data_o !== 8'hA5) $display("FAIL good_a5: got v=%b d=%h expected v=1 d=a5", valid_o, data_o); else n_pass++;
    n_total++;
    if (n_fe - fe0 + n_pe - pe0 + n_ov - ov0 != 0) $display("FAIL good_err: got %0d pulses expected 0", n_fe - fe0 + n_pe - pe0 + n_ov - ov0); else n_pass++;
    drain("good");
    n_total++;
    if (data_o !== 8'hA5) $display("FAIL good_hold: got %h expected a5", data_o); else n_pass++;
  endtask

  task automatic test_false_start();
    snap();
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    n_total++;
    if (valid_o !== 1'b0 || n_fe - fe0 + n_pe - pe0 + n_ov - ov0 != 0)
      $display("FAIL false_start: got v=%b pulses=%0d expected v=0 pulses=0", valid_o, n_fe - fe0 + n_pe - pe0 + n_ov - ov0);
    else n_pass++;
    send(8'h3C, 1'b1, 1'b1, -1);
    n_total++;
    if (valid_o !== 1'b1 || data_o !== 8'h3C) $display("FAIL false_start_next: got v=%b d=%h expected v=1 d=3c", valid_o, data_o); else n_pass++;
    drain("false_start");
  endtask

  task automatic test_frame_err();
    snap();
    send(8'h3C, 1'b1, 1'b0, -1);
    repeat (40) @(negedge clk);
    n_total++;
    if (n_fe - fe0 != 1) $display("FAIL frame_err_count: got %0d expected 1", n_fe - fe0); else n_pass++;
    n_total++;
    if (valid_o !== 1'b0 || n_pe - pe0 + n_ov - ov0 != 0) $display("FAIL frame_err_other: got v=%b other=%0d expected 0 0", valid_o, n_pe - pe0 + n_ov - ov0); else n_pass++;
    idle(5);
    send(8'h3C, 1'b1, 1'b1, -1);
    n_total++;
    if (valid_o !== 1'b1 || data_o !== 8'h3C) $display("FAIL frame_err_next: got v=%b d=%h expected v=1 d=3c", valid_o, data_o); else n_pass++;
    drain("frame_err");
  endtask

  task automatic test_parity();
    snap();
    send(8'h01, 1'b0, 1'b1, -1);
    n_total++;
    if (n_pe - pe0 != (PAR ? 1 : 0)) $display("FAIL parity_count: got %0d expected %0d", n_pe - pe0, PAR ? 1 : 0); else n_pass++;
    n_total++;
    if (valid_o !== !PAR || (!PAR && data_o !== 8'h01)) $display("FAIL parity_valid: got v=%b d=%h expected v=%b", valid_o, data_o, !PAR); else n_pass++;
    if (valid_o) drain("parity");
  endtask

  task automatic test_overrun();
    snap();
    send(8'h11, 1'b1, 1'b1, -1);
    idle(3);
    send(8'h22, 1'b1, 1'b1, -1);
    n_total++;
    if (valid_o !== 1'b1 || data_o !== 8'h11) $display("FAIL overrun_hold: got v=%b d=%h expected v=1 d=11", valid_o, data_o); else n_pass++;
    n_total++;
    if (n_ov - ov0 != 1) $display("FAIL overrun_count: got %0d expected 1", n_ov - ov0); else n_pass++;
    drain("overrun");
    snap();
    send(8'h11, 1'b1, 1'b1, -1);
    idle(3);
    send(8'h22, 1'b1, 1'b1, T_DONE - 1);
    n_total++;
    if (valid_o !== 1'b1 || data_o !== 8'h22) $display("FAIL same_cycle_load: got v=%b d=%h expected v=1 d=22", valid_o, data_o); else n_pass++;
    n_total++;
    if (n_ov - ov0 != 0) $display("FAIL same_cycle_ovr: got %0d expected 0", n_ov - ov0); else n_pass++;
    drain("same_cycle");
  endtask

  task automatic test_reset_mid();
    data_t b = 8'h5A;
    send(8'h77, 1'b1, 1'b1, -1);
    for (int c = 0; c < OS * 5 + 8; c++) begin
      rx_i = (c < OS) ? 1'b0 : b[c/OS-1];
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({valid_o, frame_err_o, parity_err_o, overrun_o} !== 4'b0 || data_o !== 8'h00)
      $display("FAIL reset_mid: got v=%b d=%h err=%b expected all 0", valid_o, data_o, {frame_err_o, parity_err_o, overrun_o});
    else n_pass++;
    @(negedge clk);
    rx_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    idle(20);
    send(8'h5A, 1'b1, 1'b1, -1);
    n_total++;
    if (valid_o !== 1'b1 || data_o !== 8'h5A) $display("FAIL reset_mid_next: got v=%b d=%h expected v=1 d=5a", valid_o, data_o); else n_pass++;
    drain("reset_mid");
  endtask

  task automatic test_random();
    logic mv = 1'b0;
    data_t md = '0;
    for (int f = 0; f < 16; f++) begin
      data_t b = data_t'($urandom);
      int kind = $urandom_range(0, 3);
      bit e_fe = (kind == 3);
      bit e_pe = PAR && kind == 2;
      bit good = !e_fe && !e_pe;
      bit e_ov = good && mv;
      if (good && !mv) begin
        mv = 1'b1;
        md = b;
      end
      snap();
      send(b, kind != 2, kind != 3, -1);
      n_total++;
      if (valid_o !== mv || (mv && data_o !== md)) $display("FAIL rand%0d_data: got v=%b d=%h expected v=%b d=%h", f, valid_o, data_o, mv, md); else n_pass++;
      n_total++;
      if (n_fe - fe0 != int'(e_fe) || n_pe - pe0 != int'(e_pe) || n_ov - ov0 != int'(e_ov))
        $display("FAIL rand%0d_err: got fe=%0d pe=%0d ov=%0d expected fe=%0d pe=%0d ov=%0d", f, n_fe - fe0, n_pe - pe0, n_ov - ov0, e_fe, e_pe, e_ov);
      else n_pass++;
      idle($urandom_range(2, 20));
      if (mv && $urandom_range(0, 1) == 1) begin
        drain("rand");
        mv = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_false_start();
    test_frame_err();
    test_parity();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences the 8-bit LSB-first serial-in/parallel-out shift register of the UART receive path. It synchronises the serial line, detects the start bit, samples each bit mid-period from an oversampling tick, and drives the shift-register enable. It checks the optional even-parity bit and the stop bit, then hands the byte to the consumer through a one-entry valid/ready holding register.

## Interface
- OVERSAMPLE, 16: baud ticks per bit; even, ≥4.
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- rx_i  input  1  asynchronous serial line, idle high
- baud_tick_i  input  1  single-cycle pulse, OVERSAMPLE per bit period
- data_o  output  data_t (W_DATA=8)  received byte, stable while valid_o=1
- valid_o  output  1  byte available
- ready_i  input  1  consumer accepts byte when valid_o&ready_i
- frame_err_o  output  1  one-cycle pulse: stop bit sampled 0
- parity_err_o  output  1  one-cycle pulse: parity mismatch (tied 0 without macro)
- overrun_o  output  1  one-cycle pulse: good frame dropped, holding register full

## Operation
- rx_i passes through a 2-FF synchroniser (reset value 1) to rx_s; 2-clk latency.
- tick_cnt (log2 OVERSAMPLE bits) counts baud_tick_i; bit_cnt (3 bits) counts data bits.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE: rx_s=0 → START, tick_cnt←0.
- START: sample on the tick where tick_cnt=OVERSAMPLE/2-1. rx_s=0 → DATA, tick_cnt←0, bit_cnt←0. rx_s=1 → IDLE; this is a false start, no error.
- DATA: sample on the tick where tick_cnt=OVERSAMPLE-1. Assert shift-register enb for exactly that clk with inp=rx_s. Then bit_cnt++ and tick_cnt←0. After the 8th bit → PARITY (macro) or STOP.
- PARITY: sample as in DATA. Latch mismatch = rx_s XOR shift-register parity output (even parity).
- STOP: sample as in DATA.
  - rx_s=0 → frame_err_o pulse, → WAIT_HIGH.
  - rx_s=1 and parity mismatch → parity_err_o pulse, byte discarded, → IDLE.
  - Otherwise, frame good → IDLE.
- WAIT_HIGH: stay until rx_s=1, then → IDLE. This blocks re-triggering on a break.
- The shift register is not cleared; 8 shifts fully overwrite it.
- Good frame delivery:
  - valid_o=0: data_o←shift register, valid_o←1.
  - valid_o=1 and ready_i=1 in the same cycle: load the new byte, valid_o stays 1, no overrun.
  - valid_o=1 and ready_i=0: overrun_o pulse, new byte dropped, data_o unchanged.
- valid_o&ready_i with no completion: valid_o←0 next clk; data_o holds its value.
- frame_err_o and overrun_o are mutually exclusive per frame. parity_err_o and overrun_o are mutually exclusive. Errors never set valid_o.

## Timing
- Reset values: data_o=0, valid_o=0, all error pulses 0, FSM=IDLE, counters 0, synchroniser=1.
- Reset is effective immediately at any point, including mid-frame. A partial frame is abandoned and a pending byte is lost.
- valid_o rises on the clk after the stop-bit sampling tick; error pulses occur on that same clk.
- Sampling point is mid-bit: OVERSAMPLE/2 ticks after start detection, then every OVERSAMPLE ticks.
- Without baud_tick_i, the FSM holds state except IDLE/WAIT_HIGH transitions, which use rx_s only.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is start + 8 data + even parity + stop (11 bits).
  - PARITY state is present; parity_err_o is live.
- UART_RX_PARITY_EN undefined:
  - Frame is start + 8 data + stop (10 bits).
  - PARITY state is absent; parity_err_o is tied 0; the shift-register parity output is unused.

## Structure
- Shared uart_pkg holds W_DATA, data_t, the rx_state_e enum, and the OVERSAMPLE default constant.
- One sub-module is instantiated: sipo, the UART 8-bit LSB-first shift register. This block drives its enb and inp and reads its out and parity.
- The synchroniser, counters, FSM and holding register are local to uart_rx_ctrl.

## Test plan
- Test conditions: baud_tick_i every clk, OVERSAMPLE=16, parity macro on unless stated.
- Frame 0xA5, parity 0, stop 1 → valid_o=1 with data_o=0xA5, no error pulses. ready_i=1 → valid_o=0 next clk.
- rx_i low for 4 ticks then high → no valid_o, no errors, FSM returns to IDLE. A following 0x3C frame is received correctly.
- Frame 0x3C with stop bit 0, rx held low 40 clks → one frame_err_o pulse, no valid_o, no new start until rx_i high.
- Frame 0x01 with parity bit 0 → parity_err_o pulse, valid_o stays 0. With macro off, the 10-bit frame 0x01 is delivered.
- Frames 0x11 then 0x22 with ready_i=0 → data_o=0x11 held, overrun_o pulse at the 0x22 stop. Repeat with ready_i=1 exactly at the 0x22 completion → data_o=0x22, no overrun.
- Assert rst during data bit 4 → all outputs at reset values. After release, frame 0x5A is received correctly.
